// File: rtl/kmp_pkg.sv
// rtl/kmp_pkg.sv - shared defaults, wildcard symbol and FSM encoding for the KMP scan engine
package kmp_pkg;

  localparam int          KMP_MAX_STRING  = 32;
  localparam int          KMP_MAX_PATTERN = 8;
  localparam int          KMP_BYTE        = 8;
  localparam int          KMP_STR_ADD     = 5;
  localparam int          KMP_PAT_ADD     = 3;
  localparam int          KMP_CNT_W       = 6;
  localparam logic [7:0]  KMP_WILD        = 8'h3F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    COMP = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } kmp_state_t;

endpackage

// File: rtl/kmp_char_cmp.sv
// rtl/kmp_char_cmp.sv - single symbol comparator with optional wildcard pattern byte
module kmp_char_cmp
  import kmp_pkg::*;
#(
  parameter int               BYTE = KMP_BYTE,
  parameter logic [BYTE-1:0]  WILD = KMP_WILD
) (
  input  logic [BYTE-1:0] str_byte,
  input  logic [BYTE-1:0] pat_byte,
  input  logic            wild_en,
  output logic            eq
);

  // A wildcard pattern byte only counts as "any" when the job enables it.
  assign eq = (str_byte == pat_byte) || (wild_en && (pat_byte == WILD));

endmodule

// File: rtl/kmp_scan_pe.sv
// rtl/kmp_scan_pe.sv - KMP substring scanner, one comparison per cycle, first/all match modes
module kmp_scan_pe
  import kmp_pkg::*;
#(
  parameter int                MAX_STRING  = KMP_MAX_STRING,
  parameter int                MAX_PATTERN = KMP_MAX_PATTERN,
  parameter int                BYTE        = KMP_BYTE,
  parameter int                STR_ADD     = KMP_STR_ADD,
  parameter int                PAT_ADD     = KMP_PAT_ADD,
  parameter int                CNT_W       = KMP_CNT_W,
  parameter logic [BYTE-1:0]   WILD        = KMP_WILD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MAX_STRING*BYTE-1:0]     str_input,
  input  logic [MAX_PATTERN*BYTE-1:0]    pat_input,
  input  logic [MAX_PATTERN*PAT_ADD-1:0] ff_result,
  input  logic [STR_ADD-1:0]             start_idx,
  input  logic [STR_ADD-1:0]             end_idx,
  input  logic [PAT_ADD-1:0]             pat_last_idx,
  input  logic                           mode,
  input  logic                           wild_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           match,
  output logic [STR_ADD-1:0]             match_idx,
  output logic                           match_last,
  output logic [CNT_W-1:0]               match_cnt
);

  kmp_state_t state, state_nxt;

  // Job snapshot: the scan never looks at the live inputs after acceptance.
  logic [MAX_STRING*BYTE-1:0]     str_q;
  logic [MAX_PATTERN*BYTE-1:0]    pat_q;
  logic [MAX_PATTERN*PAT_ADD-1:0] ff_q;
  logic [STR_ADD-1:0]             start_q, end_q;
  logic [PAT_ADD-1:0]             last_q;
  logic                           mode_q, wild_q;

  logic [STR_ADD-1:0] str_idx;
  logic [PAT_ADD-1:0] pat_idx;
  logic [PAT_ADD-1:0] pat_dec;
  logic [STR_ADD-1:0] match_idx_q;
  logic [BYTE-1:0]    str_byte, pat_byte;
  logic [PAT_ADD-1:0] ff_back, ff_tail;
  logic               eq, is_match, at_end;

  assign str_byte = str_q[str_idx*BYTE +: BYTE];
  assign pat_byte = pat_q[pat_idx*BYTE +: BYTE];
  assign pat_dec  = pat_idx - 1'b1;
  assign ff_back  = ff_q[pat_dec*PAT_ADD +: PAT_ADD];
  assign ff_tail  = ff_q[last_q*PAT_ADD +: PAT_ADD];
  assign is_match = eq && (pat_idx == last_q);
  assign at_end   = (str_idx == end_q);

  kmp_char_cmp #(
    .BYTE (BYTE),
    .WILD (WILD)
  ) u_cmp (
    .str_byte (str_byte),
    .pat_byte (pat_byte),
    .wild_en  (wild_q),
    .eq       (eq)
  );

  // Only a match record carries an index; the terminal record reports zero.
  assign match_idx = (state == EMIT) ? match_idx_q : '0;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/record flags.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    match      = 1'b0;
    match_last = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = INIT;
      end
      INIT: state_nxt = (start_q > end_q) ? DONE : COMP;
      COMP: begin
        if (is_match)    state_nxt = EMIT;
        else if (at_end) state_nxt = DONE;
      end
      EMIT: begin
        out_valid  = 1'b1;
        match      = 1'b1;
        match_last = !mode_q;
        if (out_ready) begin
          if (!mode_q)     state_nxt = IDLE;
          else if (at_end) state_nxt = DONE;
          else             state_nxt = COMP;
        end
      end
      DONE: begin
        out_valid  = 1'b1;
        match_last = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job capture, scan indices and match bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_q       <= '0;
      pat_q       <= '0;
      ff_q        <= '0;
      start_q     <= '0;
      end_q       <= '0;
      last_q      <= '0;
      mode_q      <= 1'b0;
      wild_q      <= 1'b0;
      str_idx     <= '0;
      pat_idx     <= '0;
      match_idx_q <= '0;
      match_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            str_q   <= str_input;
            pat_q   <= pat_input;
            ff_q    <= ff_result;
            start_q <= start_idx;
            end_q   <= end_idx;
            last_q  <= pat_last_idx;
            mode_q  <= mode;
            wild_q  <= wild_en;
          end
        end
        INIT: begin
          str_idx   <= start_q;
          pat_idx   <= '0;
          match_cnt <= '0;
        end
        COMP: begin
          if (is_match) begin
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            match_idx_q <= str_idx - STR_ADD'(last_q);
          end else if (!at_end) begin
            if (eq) begin
              str_idx <= str_idx + 1'b1;
              pat_idx <= pat_idx + 1'b1;
            end else if (pat_idx == '0) begin
              str_idx <= str_idx + 1'b1;
            end else begin
              pat_idx <= ff_back;
            end
          end
        end
        EMIT: begin
          // Overlapping search resumes from the pattern's own border.
          if (out_ready && mode_q && !at_end) begin
            pat_idx <= ff_tail;
            str_idx <= str_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_scan_pe.sv
// tb/tb_kmp_scan_pe.sv - directed self-checking bench for kmp_scan_pe
`timescale 1ns/1ps
module tb_kmp_scan_pe;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] str_input;
  logic [63:0]  pat_input;
  logic [23:0]  ff_result;
  logic [4:0]   start_idx, end_idx;
  logic [2:0]   pat_last_idx;
  logic         mode, wild_en, in_valid, in_ready;
  logic         out_valid, out_ready, match, match_last;
  logic [4:0]   match_idx;
  logic [5:0]   match_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kmp_scan_pe dut (
    .clk          (clk),
    .reset        (reset),
    .str_input    (str_input),
    .pat_input    (pat_input),
    .ff_result    (ff_result),
    .start_idx    (start_idx),
    .end_idx      (end_idx),
    .pat_last_idx (pat_last_idx),
    .mode         (mode),
    .wild_en      (wild_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .match        (match),
    .match_idx    (match_idx),
    .match_last   (match_last),
    .match_cnt    (match_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setup(input string s, input string p, input string f,
                       input int st, input int en, input bit md, input bit we);
    str_input = '0;
    pat_input = '0;
    ff_result = '0;
    for (int i = 0; i < s.len(); i++) str_input[i*8 +: 8] = s[i];
    for (int i = 0; i < p.len(); i++) pat_input[i*8 +: 8] = p[i];
    for (int i = 0; i < f.len(); i++) ff_result[i*3 +: 3] = 3'(f[i] - 8'd48);
    start_idx    = 5'(st);
    end_idx      = 5'(en);
    pat_last_idx = 3'(p.len() - 1);
    mode         = md;
    wild_en      = we;
  endtask

  // Called at a negedge; returns after the accepting posedge, at the next negedge.
  task automatic submit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rec(output bit ok, output logic [12:0] rec);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    rec = {match, match_idx, match_last, match_cnt};
  endtask

  task automatic xfer();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    setup("", "A", "0", 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, match, match_idx, match_last, match_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b m=%b idx=%0d last=%b cnt=%0d, want rdy=1 others 0",
               in_ready, out_valid, match, match_idx, match_last, match_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_find_first();
    bit ok;
    logic [12:0] rec;
    setup("ABABABC", "ABABC", "00120", 0, 6, 1'b0, 1'b0);
    submit(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ff_accept: got %b want 1", ok); end
    wait_rec(ok, rec);
    n_cmp++;
    if ({ok, rec} !== {1'b1, 1'b1, 5'd2, 1'b1, 6'd1}) begin
      n_fail++;
      $display("FAIL ff_record: got ok=%b rec=%h want ok=1 rec=%h", ok, rec, {1'b1, 5'd2, 1'b1, 6'd1});
    end
    xfer();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL ff_back_to_idle: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_find_all(input int stall);
    bit ok;
    logic [12:0] rec;
    setup("AAAA", "AA", "01", 0, 3, 1'b1, 1'b0);
    submit(ok);
    for (int k = 0; k < 3; k++) begin
      wait_rec(ok, rec);
      n_cmp++;
      if ({ok, rec} !== {1'b1, 1'b1, 5'(k), 1'b0, 6'(k + 1)}) begin
        n_fail++;
        $display("FAIL fa_record%0d stall=%0d: got ok=%b rec=%h want rec=%h", k, stall, ok, rec,
                 {1'b1, 5'(k), 1'b0, 6'(k + 1)});
      end
      for (int j = 0; j < stall; j++) begin
        @(negedge clk);
        n_cmp++;
        if ({out_valid, match, match_idx, match_last, match_cnt} !== {1'b1, 1'b1, 5'(k), 1'b0, 6'(k + 1)}) begin
          n_fail++;
          $display("FAIL fa_stall%0d_%0d: got ov=%b m=%b idx=%0d last=%b cnt=%0d want ov=1 m=1 idx=%0d last=0 cnt=%0d",
                   k, j, out_valid, match, match_idx, match_last, match_cnt, k, k + 1);
        end
      end
      xfer();
    end
    wait_rec(ok, rec);
    n_cmp++;
    if ({ok, rec} !== {1'b1, 1'b0, 5'd0, 1'b1, 6'd3}) begin
      n_fail++;
      $display("FAIL fa_terminal stall=%0d: got ok=%b rec=%h want rec=%h", stall, ok, rec, {1'b0, 5'd0, 1'b1, 6'd3});
    end
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, match, match_last, match_cnt} !== {1'b1, 1'b0, 1'b1, 6'd3}) begin
        n_fail++;
        $display("FAIL fa_term_stall%0d: got ov=%b m=%b last=%b cnt=%0d want 1 0 1 3",
                 j, out_valid, match, match_last, match_cnt);
      end
    end
    xfer();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL fa_idle stall=%0d: got ov=%b rdy=%b want ov=0 rdy=1", stall, out_valid, in_ready);
    end
  endtask

  task automatic test_wildcard();
    bit ok;
    logic [12:0] rec;
    setup("XABCX", "A?C", "000", 0, 4, 1'b0, 1'b1);
    submit(ok);
    wait_rec(ok, rec);
    n_cmp++;
    if ({ok, rec} !== {1'b1, 1'b1, 5'd1, 1'b1, 6'd1}) begin
      n_fail++;
      $display("FAIL wild_on: got ok=%b rec=%h want rec=%h", ok, rec, {1'b1, 5'd1, 1'b1, 6'd1});
    end
    xfer();
    setup("XABCX", "A?C", "000", 0, 4, 1'b0, 1'b0);
    submit(ok);
    wait_rec(ok, rec);
    n_cmp++;
    if ({ok, rec} !== {1'b1, 1'b0, 5'd0, 1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL wild_off: got ok=%b rec=%h want rec=%h", ok, rec, {1'b0, 5'd0, 1'b1, 6'd0});
    end
    xfer();
  endtask

  task automatic test_empty_window();
    bit ok;
    setup("ABCDEFGH", "AB", "00", 5, 3, 1'b0, 1'b0);
    // Cycles: acceptance (1), INIT (2), terminal record (3).
    submit(ok);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_init_cycle: got ov=%b want 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, match, match_idx, match_last, match_cnt} !== {1'b1, 1'b0, 5'd0, 1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL empty_terminal: got ov=%b m=%b idx=%0d last=%b cnt=%0d want 1 0 0 1 0",
               out_valid, match, match_idx, match_last, match_cnt);
    end
    xfer();
  endtask

  task automatic test_short_window();
    bit ok;
    logic [12:0] rec;
    setup("ABCABC", "ABC", "000", 3, 4, 1'b1, 1'b0);
    submit(ok);
    wait_rec(ok, rec);
    n_cmp++;
    if ({ok, rec} !== {1'b1, 1'b0, 5'd0, 1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL short_window: got ok=%b rec=%h want rec=%h", ok, rec, {1'b0, 5'd0, 1'b1, 6'd0});
    end
    xfer();
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    logic [12:0] rec;
    int seen;
    setup("AAAA", "AA", "01", 0, 3, 1'b1, 1'b0);
    submit(ok);
    wait_rec(ok, rec);
    xfer();
    // Now in COMP with one match already counted.
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, match, match_idx, match_last, match_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_comp: got rdy=%b ov=%b m=%b idx=%0d last=%b cnt=%0d want rdy=1 others 0",
               in_ready, out_valid, match, match_idx, match_last, match_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d records want 0", seen); end
    test_find_first();
  endtask

  initial begin
    test_reset();
    test_find_first();
    test_find_all(0);
    test_find_all(5);
    test_wildcard();
    test_empty_window();
    test_short_window();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
